// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory / stack front-end.
package dmem_ctrl_pkg;

  // IDLE arbitrates; the others finish multi-word transfers.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STK2 = 2'd1,
    INT2 = 2'd2,
    INT3 = 2'd3
  } state_t;

  localparam int SP_INIT_DEF     = 2047;
  localparam int STACK_LIMIT_DEF = 1024;

  // Word counts of the multi-word operations.
  localparam logic [1:0] NARROW = 2'd1;
  localparam logic [1:0] WIDE   = 2'd2;
  localparam logic [1:0] CTX    = 2'd3;

  // Requester bit positions in the request / grant vectors.
  localparam int R_INT  = 0;
  localparam int R_PUSH = 1;
  localparam int R_POP  = 2;
  localparam int R_LS   = 3;

  // Stack words live in the 2K memory, so only 11 address bits are significant.
  function automatic logic [31:0] stk_addr(input logic [10:0] a);
    return {21'b0, a};
  endfunction

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with bounds queries and neighbouring addresses.
module stack_pointer #(
  parameter int SP_INIT     = 2047,
  parameter int STACK_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  input  logic [1:0]  step,
  input  logic [1:0]  chk_n,
  output logic        can_push,
  output logic        can_pop,
  output logic [10:0] sp,
  output logic [10:0] sp_p1,
  output logic [10:0] sp_p2,
  output logic [10:0] sp_m1,
  output logic [10:0] sp_m2
);

  localparam logic [11:0] INIT12  = 12'(SP_INIT);
  localparam logic [11:0] LIMIT12 = 12'(STACK_LIMIT);

  logic [10:0] sp_q;
  logic [11:0] sp_ext;
  logic [11:0] n_ext;

  assign sp_ext = {1'b0, sp_q};
  assign n_ext  = {10'b0, chk_n};

  // sp >= limit + n - 1, rearranged so nothing goes negative.
  assign can_push = (sp_ext + 12'd1) >= (LIMIT12 + n_ext);
  assign can_pop  = (sp_ext + n_ext) <= INIT12;

  assign sp    = sp_q;
  assign sp_p1 = sp_q + 11'd1;
  assign sp_p2 = sp_q + 11'd2;
  assign sp_m1 = sp_q - 11'd1;
  assign sp_m2 = sp_q - 11'd2;

  // Pointer moves once, in the final cycle of a stack operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= INIT12[10:0];
    end else if (dec) begin
      sp_q <= sp_q - {9'b0, step};
    end else if (inc) begin
      sp_q <= sp_q + {9'b0, step};
    end
  end

endmodule

// File: rtl/dmem_stack_ctrl.sv
// Data-memory front-end: arbitrates interrupt save, stack push/pop and
// load/store, owns the stack pointer and stalls the pipeline during
// multi-word transfers.
//
// Handshake: each requester raises its req and holds it (with its operands)
// until it sees done; done is a one-cycle registered pulse, err qualifies it.
// During the done cycle the finishing requester's line is masked so the
// still-held request is not granted a second time.
module dmem_stack_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 16,
  parameter int SP_INIT     = SP_INIT_DEF,
  parameter int STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic                  push_req,
  input  logic                  pop_req,
  input  logic                  stk_wide,
  input  logic [2*DATA_W-1:0]   stk_wdata,
  input  logic                  int_req,
  input  logic [2*DATA_W-1:0]   int_pc,
  input  logic [DATA_W-1:0]     int_flags,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_cs,
  output logic [2*DATA_W-1:0]   rdata,
  output logic                  done,
  output logic                  err,
  output logic                  stall,
  output logic [ADDR_W-1:0]     sp,
  output logic                  ovf,
  output logic                  unf,
  output logic [1:0]            dbg_state
);

  state_t            state;
  logic [3:0]        fin_q;     // requester that finished, only during done
  logic              push_q;    // STK2 is a push (1) or a pop (0)
  logic [DATA_W-1:0] lo_q;      // pending low word / popped low word
  logic [DATA_W-1:0] flags_q;

  logic [3:0]  req;
  logic [3:0]  eff;
  logic [3:0]  gnt;
  logic [1:0]  gnt_n;
  logic        gnt_ok;
  logic        can_push;
  logic        can_pop;
  logic        sp_inc;
  logic        sp_dec;
  logic [1:0]  sp_step;
  logic [10:0] sp_cur;
  logic [10:0] sp_p1;
  logic [10:0] sp_p2;
  logic [10:0] sp_m1;
  logic [10:0] sp_m2;

  stack_pointer #(
    .SP_INIT     (SP_INIT),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk      (clk),
    .rst      (rst),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .step     (sp_step),
    .chk_n    (gnt_n),
    .can_push (can_push),
    .can_pop  (can_pop),
    .sp       (sp_cur),
    .sp_p1    (sp_p1),
    .sp_p2    (sp_p2),
    .sp_m1    (sp_m1),
    .sp_m2    (sp_m2)
  );

  assign req = {ls_req, pop_req, push_req, int_req};
  assign eff = req & ~fin_q;

  // Fixed-priority grant, only while idle: int > push > pop > load/store.
  always_comb begin
    gnt   = 4'b0000;
    gnt_n = NARROW;
    if (state == IDLE) begin
      if (eff[R_INT]) begin
        gnt   = 4'b0001;
        gnt_n = CTX;
      end else if (eff[R_PUSH]) begin
        gnt   = 4'b0010;
        gnt_n = stk_wide ? WIDE : NARROW;
      end else if (eff[R_POP]) begin
        gnt   = 4'b0100;
        gnt_n = stk_wide ? WIDE : NARROW;
      end else if (eff[R_LS]) begin
        gnt   = 4'b1000;
      end
    end
  end

  assign gnt_ok = (gnt[R_INT] | gnt[R_PUSH]) ? can_push :
                  gnt[R_POP]                 ? can_pop  : 1'b1;

  assign stall = (state != IDLE)
               | ((|gnt) && (gnt_n != NARROW))
               | (|(eff & ~gnt));

  assign sp        = ADDR_W'(sp_cur);
  assign dbg_state = state;

  // Stack pointer moves in the last cycle of a successful stack operation.
  always_comb begin
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    sp_step = NARROW;
    case (state)
      IDLE: begin
        if (gnt_ok && gnt_n == NARROW) begin
          sp_dec = gnt[R_PUSH];
          sp_inc = gnt[R_POP];
        end
      end
      STK2: begin
        sp_step = WIDE;
        sp_dec  = push_q;
        sp_inc  = ~push_q;
      end
      INT3: begin
        sp_step = CTX;
        sp_dec  = 1'b1;
      end
      default: ;
    endcase
  end

  // Memory port driven in the issuing cycle; silent on rejects and during reset.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (gnt[R_INT] && gnt_ok) begin
          mem_write = 1'b1;
          mem_addr  = ADDR_W'(stk_addr(sp_cur));
          mem_wdata = int_pc[2*DATA_W-1:DATA_W];
        end else if (gnt[R_PUSH] && gnt_ok) begin
          mem_write = 1'b1;
          mem_addr  = ADDR_W'(stk_addr(sp_cur));
          mem_wdata = stk_wide ? stk_wdata[2*DATA_W-1:DATA_W] : stk_wdata[DATA_W-1:0];
        end else if (gnt[R_POP] && gnt_ok) begin
          mem_read  = 1'b1;
          mem_addr  = ADDR_W'(stk_addr(sp_p1));
        end else if (gnt[R_LS]) begin
          mem_write = ls_we;
          mem_read  = ~ls_we;
          mem_addr  = ls_addr;
          mem_wdata = ls_we ? ls_wdata : '0;
        end
      end
      STK2: begin
        if (push_q) begin
          mem_write = 1'b1;
          mem_addr  = ADDR_W'(stk_addr(sp_m1));
          mem_wdata = lo_q;
        end else begin
          mem_read  = 1'b1;
          mem_addr  = ADDR_W'(stk_addr(sp_p2));
        end
      end
      INT2: begin
        mem_write = 1'b1;
        mem_addr  = ADDR_W'(stk_addr(sp_m1));
        mem_wdata = lo_q;
      end
      INT3: begin
        mem_write = 1'b1;
        mem_addr  = ADDR_W'(stk_addr(sp_m2));
        mem_wdata = flags_q;
      end
      default: ;
    endcase
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign mem_cs = mem_read | mem_write;

  // Sequencer: state, latched operands and all registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      fin_q   <= 4'b0000;
      push_q  <= 1'b0;
      lo_q    <= '0;
      flags_q <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      fin_q <= 4'b0000;
      case (state)
        IDLE: begin
          if (|gnt) begin
            if (!gnt_ok) begin
              done  <= 1'b1;
              err   <= 1'b1;
              fin_q <= gnt;
              if (gnt[R_POP]) unf <= 1'b1;
              else            ovf <= 1'b1;
            end else if (gnt_n != NARROW) begin
              state   <= gnt[R_INT] ? INT2 : STK2;
              push_q  <= gnt[R_PUSH];
              flags_q <= int_flags;
              lo_q    <= gnt[R_INT]  ? int_pc[DATA_W-1:0]    :
                         gnt[R_PUSH] ? stk_wdata[DATA_W-1:0] : mem_rdata;
            end else begin
              done  <= 1'b1;
              fin_q <= gnt;
              if (gnt[R_POP] || (gnt[R_LS] && !ls_we)) begin
                rdata <= {{DATA_W{1'b0}}, mem_rdata};
              end
            end
          end
        end
        STK2: begin
          state <= IDLE;
          done  <= 1'b1;
          fin_q <= push_q ? 4'b0010 : 4'b0100;
          if (!push_q) rdata <= {mem_rdata, lo_q};
        end
        INT2: begin
          state <= INT3;
        end
        INT3: begin
          state <= IDLE;
          done  <= 1'b1;
          fin_q <= 4'b0001;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stack_ctrl.sv
// Directed bench for dmem_stack_ctrl with a behavioural 2K x 16 memory,
// an expected-completion queue and a done-driven monitor.
module tb_dmem_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        push_req = 1'b0, pop_req = 1'b0, stk_wide = 1'b0;
  logic [31:0] stk_wdata = '0;
  logic        int_req = 1'b0;
  logic [31:0] int_pc = '0;
  logic [15:0] int_flags = '0;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_cs;
  logic [31:0] rdata;
  logic        done, err, stall, ovf, unf;
  logic [31:0] sp;
  logic [1:0]  dbg_state;

  typedef struct {
    int          line;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    logic [31:0] sp;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   pend_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  logic stall_log[int];
  logic cs_log[int];
  logic [15:0] mem [0:2047];

  dmem_stack_ctrl dut (
    .clk(clk), .rst(rst),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .push_req(push_req), .pop_req(pop_req), .stk_wide(stk_wide), .stk_wdata(stk_wdata),
    .int_req(int_req), .int_pc(int_pc), .int_flags(int_flags),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_cs(mem_cs),
    .rdata(rdata), .done(done), .err(err), .stall(stall), .sp(sp),
    .ovf(ovf), .unf(unf), .dbg_state(dbg_state)
  );

  // Clock, cycle counter and the memory model.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr[10:0]];
  always @(posedge clk) if (mem_cs && mem_write) mem[mem_addr[10:0]] <= mem_wdata;

  // Per-cycle record of stall and chip select for later checks.
  always @(negedge clk) begin
    stall_log[cyc] = stall;
    cs_log[cyc]    = mem_cs;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every done pops the oldest expectation and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      chk("cs_is_or", {31'b0, mem_cs}, {31'b0, mem_read | mem_write});
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("op%0d_latency", e.tag), cyc, e.cyc);
          chk($sformatf("op%0d_err", e.tag), {31'b0, err}, {31'b0, e.err});
          chk($sformatf("op%0d_sp", e.tag), sp, e.sp);
          if (e.chk_rd) chk($sformatf("op%0d_rdata", e.tag), rdata, e.rd);
        end
      end
    end
  end

  // Driver helpers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_op(input int line, input logic e_err, input logic e_chk,
                           input logic [31:0] e_rd, input logic [31:0] e_sp,
                           input int lat, input int tag);
    exp_t e;
    e.line = line; e.err = e_err; e.chk_rd = e_chk; e.rd = e_rd;
    e.sp = e_sp; e.cyc = cyc + lat; e.tag = tag;
    exp_q.push_back(e);
    pend_q.push_back(line);
  endtask

  task automatic drop(input int line);
    case (line)
      0: int_req = 1'b0;
      1: push_req = 1'b0;
      2: pop_req = 1'b0;
      default: ls_req = 1'b0;
    endcase
  endtask

  // Requesters hold their lines until done, then release them in issue order.
  task automatic finish_ops();
    int guard = 0;
    int line;
    while (pend_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (done) begin
        line = pend_q.pop_front();
        tick();
        drop(line);
      end
    end
    if (pend_q.size() > 0) begin
      chk("done_timeout", pend_q.size(), 32'd0);
      while (pend_q.size() > 0) drop(pend_q.pop_front());
    end
  endtask

  task automatic do_push(input logic wide, input logic [31:0] d, input logic e_err,
                         input logic [31:0] e_sp, input int tag);
    tick();
    push_req = 1'b1; stk_wide = wide; stk_wdata = d;
    expect_op(1, e_err, 1'b0, 32'h0, e_sp, (wide && !e_err) ? 2 : 1, tag);
    finish_ops();
  endtask

  task automatic do_pop(input logic wide, input logic e_err, input logic [31:0] e_rd,
                        input logic [31:0] e_sp, input int tag);
    tick();
    pop_req = 1'b1; stk_wide = wide;
    expect_op(2, e_err, !e_err, e_rd, e_sp, (wide && !e_err) ? 2 : 1, tag);
    finish_ops();
  endtask

  initial begin
    int c;
    logic [15:0] saved;

    // Reset state
    reset_dut();
    @(negedge clk);
    chk("rst_sp", sp, 32'd2047);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {27'b0, done, err, ovf, unf, mem_cs}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);

    // 1: narrow push then narrow pop
    c = cyc + 1;
    do_push(1'b0, 32'h0000_1234, 1'b0, 32'd2046, 1);
    chk("t1_mem2047", {16'b0, mem[2047]}, 32'h1234);
    chk("t1_nostall", {31'b0, stall_log[c]}, 32'd0);
    do_pop(1'b0, 1'b0, 32'h0000_1234, 32'd2047, 2);

    // 2: wide push then wide pop
    c = cyc + 1;
    do_push(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd2045, 3);
    chk("t2_mem2047", {16'b0, mem[2047]}, 32'hDEAD);
    chk("t2_mem2046", {16'b0, mem[2046]}, 32'hBEEF);
    chk("t2_stall_n", {31'b0, stall_log[c]}, 32'd1);
    chk("t2_stall_n1", {31'b0, stall_log[c+1]}, 32'd1);
    chk("t2_stall_done", {31'b0, stall_log[c+2]}, 32'd0);
    do_pop(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd2047, 4);

    // 3: int, push and load together; int first, then push, then load
    tick();
    c = cyc;
    int_req = 1'b1; int_pc = 32'h89AB_CDEF; int_flags = 16'h5A5A;
    push_req = 1'b1; stk_wide = 1'b0; stk_wdata = 32'h0000_7777;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd2047;
    expect_op(0, 1'b0, 1'b0, 32'h0, 32'd2044, 3, 5);
    expect_op(1, 1'b0, 1'b0, 32'h0, 32'd2043, 4, 6);
    expect_op(3, 1'b0, 1'b1, 32'h0000_89AB, 32'd2043, 5, 7);
    tick();
    int_pc = 32'h0; int_flags = 16'h0;   // latched at grant, must not matter
    finish_ops();
    chk("t3_mem2047", {16'b0, mem[2047]}, 32'h89AB);
    chk("t3_mem2046", {16'b0, mem[2046]}, 32'hCDEF);
    chk("t3_mem2045", {16'b0, mem[2045]}, 32'h5A5A);
    chk("t3_mem2044", {16'b0, mem[2044]}, 32'h7777);
    for (int k = 0; k < 4; k++) chk($sformatf("t3_stall_c%0d", k), {31'b0, stall_log[c+k]}, 32'd1);
    chk("t3_stall_ls", {31'b0, stall_log[c+4]}, 32'd0);

    // 4: underflow on empty stack, fill to the limit, overflow, last word
    reset_dut();
    c = cyc + 1;
    do_pop(1'b0, 1'b1, 32'h0, 32'd2047, 8);
    chk("t4_unf", {31'b0, unf}, 32'd1);
    chk("t4_ovf_clear", {31'b0, ovf}, 32'd0);
    chk("t4_unf_nostrobe", {31'b0, cs_log[c]}, 32'd0);
    for (int i = 0; i < 511; i++) begin
      logic [15:0] w;
      w = i[15:0];
      do_push(1'b1, {w, ~w}, 1'b0, 32'(2045 - 2 * i), 100);
    end
    do_push(1'b0, 32'h0000_1111, 1'b0, 32'd1024, 9);
    chk("t4_mem1025", {16'b0, mem[1025]}, 32'h1111);
    chk("t4_mem2046", {16'b0, mem[2046]}, 32'hFFFF);
    c = cyc + 1;
    do_push(1'b1, 32'h5555_AAAA, 1'b1, 32'd1024, 10);
    chk("t4_ovf", {31'b0, ovf}, 32'd1);
    chk("t4_ovf_nostrobe", {31'b0, cs_log[c]}, 32'd0);
    do_push(1'b0, 32'h0000_CAFE, 1'b0, 32'd1023, 11);
    chk("t4_mem1024", {16'b0, mem[1024]}, 32'hCAFE);
    chk("t4_unf_sticky", {31'b0, unf}, 32'd1);

    // 5: store then load, sp untouched
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd5; ls_wdata = 16'h00AA;
    expect_op(3, 1'b0, 1'b0, 32'h0, 32'd1023, 1, 12);
    finish_ops();
    chk("t5_mem5", {16'b0, mem[5]}, 32'h00AA);
    tick();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd5;
    expect_op(3, 1'b0, 1'b1, 32'h0000_00AA, 32'd1023, 1, 13);
    finish_ops();

    // 6: reset during INT2 aborts without done; first word stays
    reset_dut();
    saved = mem[2046];
    tick();
    int_req = 1'b1; int_pc = 32'h1357_2468; int_flags = 16'h0F0F;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_int2", {30'b0, dbg_state}, 32'd2);
    chk("t6_no_strobe_in_rst", {31'b0, mem_cs}, 32'd0);
    tick();
    rst = 1'b0; int_req = 1'b0;
    @(negedge clk);
    chk("t6_idle", {30'b0, dbg_state}, 32'd0);
    chk("t6_sp", sp, 32'd2047);
    chk("t6_no_done", {31'b0, done}, 32'd0);
    repeat (4) @(negedge clk);
    chk("t6_mem2047", {16'b0, mem[2047]}, 32'h1357);
    chk("t6_mem2046_kept", {16'b0, mem[2046]}, {16'b0, saved});

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
